pwm_multi_phase: RTL and testbench

- N-channel, centre-aligned PWM generator with complementary high/low outputs and per-transition dead-time insertion.
- Successor to the fixed three-phase PWM stage behind the current-control loop: channel count, counter width and dead-time width are parametrised.
- Duty, period and dead-time pass through shadow registers and are applied only at the counter valley.
- Sits between the inverse-Park/SVM stage (duty producer) and the gate-driver pins.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_deadtime.sv | 63 ++++++
 rtl/pwm_multi_phase.sv | 128 ++++++++++++
 tb/tb_pwm_multi_phase.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the multi-phase centre-aligned PWM block.
//   dir_t  - counter direction
//   cnt_t  - period counter / compare value
//   dt_t   - dead-time count
//   cfg_t  - period, per-channel duty, dead-time; used for both the pending
//            (shadow) register and the active register.
// The PWM_* constants size the config struct, so the top's parameters
// default to them and must match them.
package pwm_pkg;

    localparam int PWM_N_CH      = 3;
    localparam int PWM_CNT_WIDTH = 16;
    localparam int PWM_DT_WIDTH  = 8;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    typedef logic [PWM_CNT_WIDTH-1:0] cnt_t;
    typedef logic [PWM_DT_WIDTH-1:0]  dt_t;

    typedef struct packed {
        cnt_t                   period;
        cnt_t [PWM_N_CH-1:0]    duty;
        dt_t                    deadtime;
    } cfg_t;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: one channel of complementary gate drive with dead-time.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : force both gates low and forget the last raw level
//   i_raw        : raw compare result (1 = high side wants to conduct)
//   i_dt         : dead-time in clock cycles, latched on every raw edge
//   o_hi, o_lo   : registered high/low side gates, never both high
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_raw,
    input  logic [DT_WIDTH-1:0] i_dt,
    output logic                o_hi,
    output logic                o_lo
);

    logic                r_prev;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic                r_hi;
    logic                r_lo;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_prev   <= 1'b0;
            r_dt_cnt <= '0;
            r_hi     <= 1'b0;
            r_lo     <= 1'b0;
        end else if (i_raw != r_prev) begin
            // Every raw edge restarts the dead-time window; the side being
            // released drops immediately, the other side waits.
            r_prev   <= i_raw;
            r_dt_cnt <= i_dt;
            if (i_dt == '0) begin
                r_hi <= i_raw;
                r_lo <= ~i_raw;
            end else begin
                r_hi <= 1'b0;
                r_lo <= 1'b0;
            end
        end else if (r_dt_cnt != '0) begin
            r_dt_cnt <= r_dt_cnt - 1'b1;
            // Last dead-time cycle: assert the new side on this edge.
            if (r_dt_cnt == DT_WIDTH'(1)) begin
                r_hi <= i_raw;
                r_lo <= ~i_raw;
            end else begin
                r_hi <= 1'b0;
                r_lo <= 1'b0;
            end
        end else begin
            r_hi <= i_raw;
            r_lo <= ~i_raw;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/pwm_multi_phase.sv
// pwm_multi_phase: N-channel centre-aligned PWM with complementary outputs
// and per-edge dead-time. Configuration is offered through a valid/ready
// shadow slot and becomes active only at a counter valley (cnt == 0).
//   clk, rst     : clock, synchronous active-high reset
//   enable       : run counter/outputs; 0 holds cnt at 0 and gates low
//   valid, ready : config handshake (captured on valid & ready)
//   period_top   : counter peak P
//   duty_in      : per-channel compare, ch i at [i*CNT_WIDTH +: CNT_WIDTH]
//   deadtime     : dead-time D in clock cycles
//   pwm_hi_out   : high-side gates
//   pwm_lo_out   : low-side gates
//   sync_out     : one-cycle pulse per valley while enabled
module pwm_multi_phase
    import pwm_pkg::*;
#(
    parameter int N_CH      = PWM_N_CH,
    parameter int CNT_WIDTH = PWM_CNT_WIDTH,
    parameter int DT_WIDTH  = PWM_DT_WIDTH
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      valid,
    output logic                      ready,
    input  logic [CNT_WIDTH-1:0]      period_top,
    input  logic [N_CH*CNT_WIDTH-1:0] duty_in,
    input  logic [DT_WIDTH-1:0]       deadtime,
    output logic [N_CH-1:0]           pwm_hi_out,
    output logic [N_CH-1:0]           pwm_lo_out,
    output logic                      sync_out
);

    cfg_t   r_active;
    cfg_t   r_pending;
    logic   r_pend_full;
    cnt_t   r_cnt;
    dir_t   r_dir;
    logic   r_sync;

    cfg_t            w_offer;
    logic            w_valley;
    logic            w_load;
    cnt_t            w_period;
    logic            w_off;
    logic [N_CH-1:0] w_raw;

    always_comb begin
        w_offer          = '0;
        w_offer.period   = period_top;
        w_offer.deadtime = deadtime;
        for (int i = 0; i < N_CH; i++)
            w_offer.duty[i] = duty_in[i*CNT_WIDTH +: CNT_WIDTH];
    end

    assign w_valley = (r_cnt == '0);
    assign w_load   = w_valley & r_pend_full;
    // The step out of a valley already uses the period being loaded there,
    // so a new P (including P = 0) takes effect without a stray count.
    assign w_period = w_load ? r_pending.period : r_active.period;
    assign w_off    = ~enable | (r_active.period == '0);

    // Triangle counter: 0,1..P,P-1..1,0 -> 2P cycles per period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_dir <= UP;
        end else if (!enable || w_period == '0) begin
            r_cnt <= '0;
            r_dir <= UP;
        end else if (r_dir == UP) begin
            if (r_cnt < w_period) begin
                r_cnt <= r_cnt + cnt_t'(1);
            end else begin
                r_dir <= DOWN;
                r_cnt <= r_cnt - cnt_t'(1);
            end
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - cnt_t'(1);
            end else begin
                r_dir <= UP;
                r_cnt <= r_cnt + cnt_t'(1);
            end
        end
    end

    // Shadow slot. Load and capture are exclusive (load needs a full slot,
    // capture an empty one), so a capture on a valley waits for the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else if (w_load) begin
            r_active    <= r_pending;
            r_pend_full <= 1'b0;
        end else if (valid && !r_pend_full) begin
            r_pending   <= w_offer;
            r_pend_full <= 1'b1;
        end
    end

    // Registered so the pulse lines up with the registered gate outputs.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 1'b0;
        else     r_sync <= enable & w_valley;
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_raw[gi] = (r_cnt < r_active.duty[gi]);

        pwm_deadtime #(
            .DT_WIDTH (DT_WIDTH)
        ) u_dt (
            .i_clk (clk),
            .i_rst (rst),
            .i_clr (w_off),
            .i_raw (w_raw[gi]),
            .i_dt  (r_active.deadtime),
            .o_hi  (pwm_hi_out[gi]),
            .o_lo  (pwm_lo_out[gi])
        );
    end

    assign ready    = ~r_pend_full;
    assign sync_out = r_sync;

endmodule

// File: tb/tb_pwm_multi_phase.sv
module tb_pwm_multi_phase;

    localparam int NC  = 3;
    localparam int CW  = 16;
    localparam int DW  = 8;
    localparam int BIG = 1000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic                valid = 1'b0;
    logic                ready;
    logic [CW-1:0]       period_top = '0;
    logic [NC*CW-1:0]    duty_in = '0;
    logic [DW-1:0]       deadtime = '0;
    logic [NC-1:0]       pwm_hi_out;
    logic [NC-1:0]       pwm_lo_out;
    logic                sync_out;

    pwm_multi_phase dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .valid      (valid),
        .ready      (ready),
        .period_top (period_top),
        .duty_in    (duty_in),
        .deadtime   (deadtime),
        .pwm_hi_out (pwm_hi_out),
        .pwm_lo_out (pwm_lo_out),
        .sync_out   (sync_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: position within the period as a phase index
    // 0..2P-1, dead-time as "cycles since the raw level last changed".
    int m_ph;
    int mP, mD, mduty[NC];
    int pP, pD, pduty[NC];
    bit m_pf;
    bit m_prev[NC];
    int m_age[NC], m_need[NC];
    logic [NC-1:0] e_hi, e_lo;
    logic          e_sync;

    int w_hi[NC], w_lo[NC], w_sync;

    function automatic int cnt_of();
        if (mP == 0) return 0;
        return (m_ph <= mP) ? m_ph : 2*mP - m_ph;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int c;
        bit vly, off, rw;
        c   = cnt_of();
        vly = (c == 0);
        off = !enable || (mP == 0);
        if (rst) begin
            m_ph = 0; mP = 0; mD = 0; pP = 0; pD = 0; m_pf = 0;
            for (int i = 0; i < NC; i++) begin
                mduty[i] = 0; pduty[i] = 0;
                m_prev[i] = 0; m_age[i] = BIG; m_need[i] = 0;
            end
            e_hi = '0; e_lo = '0; e_sync = 1'b0;
            return;
        end
        e_sync = enable && vly;
        for (int i = 0; i < NC; i++) begin
            rw = (c < mduty[i]);
            if (off) begin
                m_prev[i] = 0; m_age[i] = BIG; m_need[i] = 0;
                e_hi[i] = 1'b0; e_lo[i] = 1'b0;
            end else begin
                if (rw != m_prev[i]) begin
                    m_prev[i] = rw; m_age[i] = 0; m_need[i] = mD;
                end else if (m_age[i] < BIG) begin
                    m_age[i]++;
                end
                e_hi[i] = rw  && (m_age[i] >= m_need[i]);
                e_lo[i] = !rw && (m_age[i] >= m_need[i]);
            end
        end
        if (vly && m_pf) begin
            mP = pP; mD = pD; m_pf = 0;
            for (int i = 0; i < NC; i++) mduty[i] = pduty[i];
        end else if (valid && !m_pf) begin
            pP = int'(period_top); pD = int'(deadtime); m_pf = 1;
            for (int i = 0; i < NC; i++) pduty[i] = int'(duty_in[i*CW +: CW]);
        end
        if (!enable || mP == 0) m_ph = 0;
        else                    m_ph = (m_ph + 1) % (2*mP);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("hi", 32'(pwm_hi_out), 32'(e_hi));
        chk("lo", 32'(pwm_lo_out), 32'(e_lo));
        chk("sync", 32'(sync_out), 32'(e_sync));
        chk("ready", 32'(ready), 32'(!m_pf));
        chk("overlap", 32'(pwm_hi_out & pwm_lo_out), 32'h0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_cfg(input int p, input int d0, input int d1, input int d2, input int dt);
        period_top = CW'(p);
        duty_in    = {CW'(d2), CW'(d1), CW'(d0)};
        deadtime   = DW'(dt);
    endtask

    // Offer a config and hold it until the slot takes it.
    task automatic offer(input int p, input int d0, input int d1, input int d2, input int dt);
        bit took;
        set_cfg(p, d0, d1, d2, dt);
        valid = 1'b1;
        took  = 1'b0;
        for (int k = 0; k < 100 && !took; k++) begin
            took = !m_pf;
            step();
        end
        valid = 1'b0;
        chk("offer_taken", 32'(took), 32'h1);
    endtask

    task automatic wait_ph(input int target);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (m_ph == target) hit = 1'b1;
            else step();
        end
        chk("wait_phase", 32'(hit), 32'h1);
    endtask

    task automatic window(input int n);
        for (int i = 0; i < NC; i++) begin w_hi[i] = 0; w_lo[i] = 0; end
        w_sync = 0;
        for (int k = 0; k < n; k++) begin
            step();
            for (int i = 0; i < NC; i++) begin
                w_hi[i] += int'(pwm_hi_out[i]);
                w_lo[i] += int'(pwm_lo_out[i]);
            end
            w_sync += int'(sync_out);
        end
    endtask

    initial begin
        bit cap;

        // Reset state
        run(3);
        rst = 1'b0;
        run(2);

        // 1: P=8, duty {4,2,9}, D=0
        enable = 1'b1;
        offer(8, 4, 2, 9, 0);
        run(40);
        window(32);
        chk("t1_ch0_hi", 32'(w_hi[0]), 32'd14);
        chk("t1_ch1_hi", 32'(w_hi[1]), 32'd6);
        chk("t1_ch2_hi", 32'(w_hi[2]), 32'd32);
        chk("t1_ch2_lo", 32'(w_lo[2]), 32'd0);
        chk("t1_ch0_lo", 32'(w_lo[0]), 32'd18);
        chk("t1_sync",   32'(w_sync),  32'd2);

        // 2: D=3, 50 periods
        offer(8, 4, 2, 9, 3);
        run(800);
        window(16);
        chk("t2_ch0_hi", 32'(w_hi[0]), 32'd4);
        chk("t2_ch0_lo", 32'(w_lo[0]), 32'd6);

        // 3: mid-period duty change at cnt=5 on the way up
        offer(8, 4, 2, 9, 0);
        run(40);
        wait_ph(5);
        set_cfg(8, 6, 2, 9, 0);
        valid = 1'b1;
        step();
        valid = 1'b0;
        chk("t3_ready_low", 32'(ready), 32'h0);
        run(40);
        window(16);
        chk("t3_ch0_hi", 32'(w_hi[0]), 32'd11);

        // 4: boundaries
        offer(8, 0, 16'hFFFF, 3, 2);
        run(40);
        window(16);
        chk("t4_zero_hi", 32'(w_hi[0]), 32'd0);
        chk("t4_zero_lo", 32'(w_lo[0]), 32'd16);
        chk("t4_full_hi", 32'(w_hi[1]), 32'd16);
        offer(0, 4, 2, 9, 0);
        run(20);
        window(8);
        chk("t4_p0_sync", 32'(w_sync), 32'd8);
        chk("t4_p0_hi", 32'(w_hi[0] + w_hi[1] + w_hi[2]), 32'd0);
        chk("t4_p0_lo", 32'(w_lo[0] + w_lo[1] + w_lo[2]), 32'd0);

        // 5: pulse shorter than dead-time, then enable drop mid-period
        offer(8, 4, 4, 4, 10);
        run(60);
        window(16);
        chk("t5_hi", 32'(w_hi[0]), 32'd0);
        chk("t5_lo", 32'(w_lo[0]), 32'd0);
        wait_ph(5);
        enable = 1'b0;
        step();
        chk("t5_dis_hi", 32'(pwm_hi_out | pwm_lo_out), 32'h0);
        run(5);
        enable = 1'b1;
        run(20);

        // 6: reset at cnt=5 with a full pending slot
        offer(8, 4, 2, 9, 1);
        run(40);
        wait_ph(5);
        set_cfg(8, 7, 7, 7, 0);
        valid = 1'b1;
        step();
        valid = 1'b0;
        rst = 1'b1;
        step();
        chk("t6_rst_ready", 32'(ready), 32'h1);
        rst = 1'b0;
        run(20);
        window(8);
        chk("t6_no_apply", 32'(w_hi[0] + w_hi[1] + w_hi[2]), 32'd0);
        chk("t6_sync", 32'(w_sync), 32'd8);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if (!valid && $urandom_range(0, 29) == 0) begin
                set_cfg($urandom_range(0, 12),
                        ($urandom_range(0, 9) == 9) ? 16'hFFFF : $urandom_range(0, 14),
                        ($urandom_range(0, 9) == 9) ? 16'hFFFF : $urandom_range(0, 14),
                        $urandom_range(0, 14),
                        $urandom_range(0, 5));
                valid = 1'b1;
            end
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            rst = ($urandom_range(0, 199) == 0);
            cap = valid && !m_pf;
            step();
            if (cap || rst) valid = 1'b0;
        end
        rst = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
